// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the AXI-stream to Wishbone byte bridge.
package wb_bridge_pkg;

    // Frame parser / bus-cycle controller states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WDATA     = 3'd2,
        S_WB        = 3'd3,
        S_RESP_STAT = 3'd4,
        S_RESP_DATA = 3'd5
    } state_t;

    // Command opcodes
    localparam logic [7:0] OP_WRITE = 8'hA1;
    localparam logic [7:0] OP_READ  = 8'hA2;

    // Status byte values returned ahead of any read data
    localparam logic [7:0] ST_ACK = 8'h00;
    localparam logic [7:0] ST_ERR = 8'h01;
    localparam logic [7:0] ST_RTY = 8'h02;
    localparam logic [7:0] ST_TMO = 8'h03;

    // Resolve simultaneous terminations: err beats rty beats ack; none means watchdog
    function automatic logic [7:0] term_status(input logic ack, input logic err, input logic rty);
        if (err)      return ST_ERR;
        else if (rty) return ST_RTY;
        else if (ack) return ST_ACK;
        else          return ST_TMO;
    endfunction

endpackage

// File: rtl/axis_wb_master.sv
// axis_wb_master: parses command frames from a byte stream and runs one classic
// Wishbone cycle per frame, answering with a status byte (plus read data on a
// successful read). Optional watchdog: define AXIS_WB_MASTER_TIMEOUT_EN.
module axis_wb_master
    import wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              s_axis_data,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    output logic [7:0]              m_axis_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    output logic                    o_busy
);

    state_t                  state_q;
    logic [1:0]              cnt_q;       // byte index within the current field
    logic                    is_wr_q;     // opcode of the frame being parsed
    logic [31:0]             adr_sh_q;    // address bytes, shifted in MSB first
    logic [31:0]             rdata_q;     // read data, shifted out MSB first
    logic                    s_rdy_q;
    logic                    m_vld_q;
    logic [7:0]              m_data_q;
    logic [7:0]              status_q;
    logic                    cyc_q;
    logic [ADDR_WIDTH-1:0]   wb_adr_q;
    logic [DATA_WIDTH-1:0]   wb_dat_q;
    logic                    wb_we_q;

    logic                    s_fire;
    logic                    m_fire;
    logic [31:0]             adr_next;
    logic [DATA_WIDTH-1:0]   dat_next;
    logic                    tmo_hit;
    logic                    wb_term;

    assign s_fire   = s_axis_valid & s_rdy_q;
    assign m_fire   = m_vld_q & m_axis_ready;
    assign adr_next = {adr_sh_q[23:0], s_axis_data};
    assign dat_next = {wb_dat_q[DATA_WIDTH-9:0], s_axis_data};

`ifdef AXIS_WB_MASTER_TIMEOUT_EN
    // Watchdog width: 8 bits covers the default, 16 bits for longer limits
    localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = cyc_q && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent with cyc high; cleared whenever the bus is idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !cyc_q || wb_term) tmo_q <= '0;
        else                              tmo_q <= tmo_q + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign wb_term = wb_ack_i | wb_err_i | wb_rty_i | tmo_hit;

    // Frame parser, bus cycle and response sequencer with registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            is_wr_q  <= 1'b0;
            adr_sh_q <= '0;
            rdata_q  <= '0;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            status_q <= '0;
            cyc_q    <= 1'b0;
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            wb_we_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    s_rdy_q <= 1'b1;
                    cnt_q   <= 2'd0;
                    // Unknown opcodes are swallowed without a response
                    if (s_fire && (s_axis_data == OP_WRITE || s_axis_data == OP_READ)) begin
                        is_wr_q <= (s_axis_data == OP_WRITE);
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s_fire) begin
                        adr_sh_q <= adr_next;
                        cnt_q    <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (is_wr_q) begin
                                state_q <= S_WDATA;
                            end else begin
                                // Read frame complete: start the cycle now
                                wb_adr_q <= adr_next[ADDR_WIDTH-1:0];
                                wb_we_q  <= 1'b0;
                                cyc_q    <= 1'b1;
                                s_rdy_q  <= 1'b0;
                                state_q  <= S_WB;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (s_fire) begin
                        cnt_q <= cnt_q + 2'd1;
                        // Write data is shifted straight into the bus data register;
                        // it is only observed once cyc is raised.
                        wb_dat_q <= dat_next;
                        if (cnt_q == 2'd3) begin
                            wb_adr_q <= adr_sh_q[ADDR_WIDTH-1:0];
                            wb_we_q  <= 1'b1;
                            cyc_q    <= 1'b1;
                            s_rdy_q  <= 1'b0;
                            state_q  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_term) begin
                        cyc_q    <= 1'b0;
                        status_q <= term_status(wb_ack_i, wb_err_i, wb_rty_i);
                        m_data_q <= term_status(wb_ack_i, wb_err_i, wb_rty_i);
                        m_vld_q  <= 1'b1;
                        if (wb_ack_i && !wb_err_i && !wb_rty_i)
                            rdata_q <= wb_dat_i[31:0];
                        state_q  <= S_RESP_STAT;
                    end
                end
                S_RESP_STAT: begin
                    if (m_fire) begin
                        cnt_q <= 2'd0;
                        if (status_q == ST_ACK && !wb_we_q) begin
                            m_data_q <= rdata_q[31:24];
                            rdata_q  <= {rdata_q[23:0], 8'h00};
                            state_q  <= S_RESP_DATA;
                        end else begin
                            m_vld_q <= 1'b0;
                            s_rdy_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RESP_DATA: begin
                    if (m_fire) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            m_vld_q <= 1'b0;
                            s_rdy_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            m_data_q <= rdata_q[31:24];
                            rdata_q  <= {rdata_q[23:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    m_vld_q <= 1'b0;
                    s_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_axis_ready = s_rdy_q;
    assign m_axis_valid = m_vld_q;
    assign m_axis_data  = m_data_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_sel_o     = {(DATA_WIDTH/8){cyc_q}};
    assign wb_adr_o     = wb_adr_q;
    assign wb_dat_o     = wb_dat_q;
    assign wb_we_o      = wb_we_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule
